// File: rtl/multi_ch_uart_tx.sv
// multi_ch_uart_tx: N-channel FIFO-to-serial transmitter.
// Each channel buffers words in its own FIFO. A round-robin arbiter picks the
// next non-empty channel, and one shared serializer sends a tagged frame per
// word on tx: start 0, channel ID (LSB first), data (LSB first), optional
// parity, stop 1. Every bit is held for CLK_DIV clock cycles.
module multi_ch_uart_tx #(
  parameter int DATA_W  = 8,
  parameter int N_CH    = 3,
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 16,
  parameter int PARITY  = 0   // 0 = none, 1 = even, 2 = odd
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_CH-1:0]        wr_en,
  input  logic [N_CH*DATA_W-1:0] data_in,
  output logic [N_CH-1:0]        full,
  output logic [N_CH-1:0]        ovf,
  output logic                   busy,
  output logic                   tx
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PAR_W = (PARITY != 0) ? 1 : 0;
  localparam int F     = 1 + CH_W + DATA_W + PAR_W + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int BW    = $clog2(F);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
  localparam logic [BW-1:0]   LAST_BIT = BW'(F - 1);
  localparam logic [DW-1:0]   LAST_DIV = DW'(CLK_DIV - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  // Channel FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem    [N_CH][DEPTH];
  logic [AW-1:0]     wr_ptr [N_CH];
  logic [AW-1:0]     rd_ptr [N_CH];
  logic [CW-1:0]     count  [N_CH];
  logic [CW-1:0]     cnt_nxt[N_CH];

  logic [N_CH-1:0]   not_empty;
  logic [N_CH-1:0]   push;
  logic [N_CH-1:0]   pop;

  // Arbiter / serializer state
  state_t            state;
  logic [CH_W-1:0]   last;
  logic [CH_W-1:0]   grant;
  logic              any_ready;
  logic              do_pop;
  logic [DATA_W-1:0] pop_data;
  logic              par;
  logic [F-1:0]      frame;
  logic [F-2:0]      shreg;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;

  // Per-channel push/pop qualification and next occupancy
  // NOTE: every signal written in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      not_empty[i] = (count[i] != '0);
      // A write against a full FIFO is dropped even if the same edge pops it.
      push[i]      = wr_en[i] & ~full[i];
      pop[i]       = do_pop & (grant == CH_W'(i));
      cnt_nxt[i]   = count[i];
      case ({push[i], pop[i]})
        2'b10:   cnt_nxt[i] = count[i] + CW'(1);
        2'b01:   cnt_nxt[i] = count[i] - CW'(1);
        default: cnt_nxt[i] = count[i];
      endcase
    end
  end

  // Round-robin grant: first non-empty channel after last, wrapping at N_CH
  always_comb begin
    int  idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    any_ready = |not_empty;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(last) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      for (int i = 0; i < N_CH; i++) begin
        if (!found && (i == idx) && not_empty[i]) begin
          grant = CH_W'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign do_pop = (state == IDLE) && start && any_ready;

  // Head word of the granted channel
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == CH_W'(i)) pop_data = mem[i][rd_ptr[i]];
    end
  end

  // Frame assembly: start, ID, data, optional parity, stop (bit 0 sent first)
  always_comb begin
    par   = ^{grant, pop_data};
    frame = '1;
    frame[0] = 1'b0;
    frame[1 +: CH_W] = grant;
    frame[1 + CH_W +: DATA_W] = pop_data;
    if (PARITY != 0) frame[F-2] = (PARITY == 2) ? ~par : par;
  end

  // FIFO data array write port
  // NOTE: the storage array is deliberately not reset; the reset pointers and counts alone decide which entries are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= data_in[i*DATA_W +: DATA_W];
    end
  end

  // FIFO pointers, occupancy, full and sticky overflow flags
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      full <= '0;
      ovf  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= cnt_nxt[i];
        full[i]  <= (cnt_nxt[i] == CNT_FULL);
        if (wr_en[i] && full[i]) ovf[i] <= 1'b1;
      end
    end
  end

  // Serializer FSM with registered tx/busy and the arbiter's last pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      last    <= LAST_CH;
      shreg   <= '1;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (do_pop) begin
            state   <= SEND;
            busy    <= 1'b1;
            last    <= grant;
            tx      <= frame[0];
            shreg   <= frame[F-1:1];
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        SEND: begin
          if (div_cnt == LAST_DIV) begin
            div_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              // Last cycle of the stop bit: return the line to idle.
              state <= IDLE;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx      <= shreg[0];
              shreg   <= {1'b1, shreg[F-2:1]};
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
